// File: rtl/sid_write_sequencer.sv
// sid_write_sequencer: timed command FIFO feeding the SID register write port.
// Each command {DELAY, ADDR, DATA} waits DELAY TICKs after the previous write,
// then produces a single-cycle WR strobe with ADDR/DATA.
// Optional statistics outputs (WR_COUNT, STARVED) exist when SID_WRSEQ_STATS_EN
// is defined; without it the core behaves identically.
module sid_write_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_W    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [DELAY_W-1:0] CMD_DELAY,
  input  logic [4:0]         CMD_ADDR,
  input  logic [7:0]         CMD_DATA,
  output logic               WR,
  output logic [4:0]         ADDR,
  output logic [7:0]         DATA,
  output logic               BUSY
`ifdef SID_WRSEQ_STATS_EN
  ,
  output logic [15:0]        WR_COUNT,
  output logic               STARVED
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = DELAY_W + 13;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  logic [CW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [4:0]         cur_addr_q, cur_addr_d, addr_q, addr_d;
  logic [7:0]         cur_data_q, cur_data_d, data_q, data_d;
  logic               wr_q, wr_d, busy_q, busy_d, ready_q, ready_d;
  logic               empty, push, pop, issue;
  logic [DELAY_W-1:0] head_delay;
  logic [4:0]         head_addr;
  logic [7:0]         head_data;

  assign {head_delay, head_addr, head_data} = fifo_mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  // ready_q always equals !full, so accepting never looks at CMD_VALID combinationally
  assign push  = CMD_VALID & ready_q;
  assign pop   = (state_q == S_IDLE) & ~empty;

  // Command storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wptr_q[AW-1:0]] <= {CMD_DELAY, CMD_ADDR, CMD_DATA};
  end

  // Next-state logic: FIFO pointers, sequencing FSM, registered outputs.
  // WR is registered on the way out of WRITE (or on the last TICK in WAIT), so the
  // strobe cycle is already IDLE and can pop the next command: writes 2 CLK apart.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    cur_data_d = cur_data_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cur_addr_d = head_addr;
          cur_data_d = head_data;
          if (head_delay == '0) begin
            state_d = S_WRITE;
          end else begin
            cnt_d   = head_delay;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (TICK) begin
          if (cnt_q == DELAY_W'(1)) issue = 1'b1;
          else                      cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      S_WRITE: issue = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      wr_d    = 1'b1;
      addr_d  = cur_addr_q;
      data_d  = cur_data_q;
      cnt_d   = '0;
      state_d = S_IDLE;
    end
    wptr_d  = wptr_q + (AW+1)'(push);
    rptr_d  = rptr_q + (AW+1)'(pop);
    ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
    busy_d  = (state_q != S_IDLE) | ~empty | push;
  end

  // State and output registers, synchronous reset discards all pending work
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cur_addr_q <= '0;
      cur_data_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cur_addr_q <= cur_addr_d;
      cur_data_q <= cur_data_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign CMD_READY = ready_q;
  assign WR        = wr_q;
  assign ADDR      = addr_q;
  assign DATA      = data_q;
  assign BUSY      = busy_q;

`ifdef SID_WRSEQ_STATS_EN
  logic [15:0] wr_count_q, wr_count_d;
  logic        starved_q, starved_d;

  // Write counter (free-running wrap) and queue-ran-dry pulse at write issue
  always_comb begin
    wr_count_d = wr_count_q + 16'(wr_q);
    starved_d  = issue & empty;
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_count_q <= '0;
      starved_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      starved_q  <= starved_d;
    end
  end

  assign WR_COUNT = wr_count_q;
  assign STARVED  = starved_q;
`endif

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Bench for sid_write_sequencer: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against an edge-indexed queue model.
module tb_sid_write_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TICK = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_DELAY = '0;
  logic [4:0]  CMD_ADDR = '0;
  logic [7:0]  CMD_DATA = '0;
  logic        WR;
  logic [4:0]  ADDR;
  logic [7:0]  DATA;
  logic        BUSY;
`ifdef SID_WRSEQ_STATS_EN
  logic [15:0] WR_COUNT;
  logic        STARVED;
`endif

  sid_write_sequencer #(.FIFO_DEPTH(16), .DELAY_W(16)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DELAY(CMD_DELAY), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .WR(WR), .ADDR(ADDR), .DATA(DATA), .BUSY(BUSY)
`ifdef SID_WRSEQ_STATS_EN
    , .WR_COUNT(WR_COUNT), .STARVED(STARVED)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int dly; logic [4:0] a; logic [7:0] d; } cmd_t;
  cmd_t        mq[$];
  cmd_t        m_cur;
  bit          m_act;
  int          m_left, m_pop_edge, n_edge;
  logic        m_wr, m_busy, m_rdy, m_starved;
  logic [4:0]  m_a;
  logic [7:0]  m_d;
  logic [15:0] m_cnt;

  // One clock edge of the spec's behaviour, in terms of edge numbers:
  // a command popped at edge p fires at p+1 if DELAY=0, else at the edge that
  // samples its DELAY-th TICK after p. The FIFO pops at the edge after a fire.
  task automatic model_edge(input logic rst, vld, tick, input int dly,
                            input logic [4:0] a, input logic [7:0] d);
    bit push, fire, busy_new;
    n_edge++;
    if (rst) begin
      mq.delete(); m_act = 0; m_wr = 0; m_a = 0; m_d = 0; m_busy = 0; m_rdy = 1;
      m_cnt = 0; m_starved = 0;
      return;
    end
    push     = vld && m_rdy;
    busy_new = m_act || (mq.size() > 0) || push;
    m_cnt    = m_cnt + 16'(m_wr);
    fire     = 0;
    if (m_act) begin
      if (m_cur.dly == 0) fire = (n_edge == m_pop_edge + 1);
      else if (tick) begin
        m_left--;
        fire = (m_left == 0);
      end
    end
    m_starved = fire && (mq.size() == 0);
    m_wr = fire;
    if (fire) begin
      m_a = m_cur.a; m_d = m_cur.d; m_act = 0;
    end else if (!m_act && mq.size() > 0) begin
      m_cur = mq.pop_front(); m_act = 1; m_pop_edge = n_edge; m_left = m_cur.dly;
    end
    if (push) mq.push_back('{dly, a, d});
    m_rdy  = (mq.size() < 16);
    m_busy = busy_new;
  endtask

  // Drive one cycle of inputs, clock it, then compare DUT against the model
  task automatic step(input logic rst, vld, tick, input logic [15:0] dly,
                      input logic [4:0] a, input logic [7:0] d);
    RST = rst; CMD_VALID = vld; TICK = tick; CMD_DELAY = dly; CMD_ADDR = a; CMD_DATA = d;
    @(posedge CLK);
    model_edge(rst, vld, tick, int'(dly), a, d);
    #1;
    chk("wr", 32'(WR), 32'(m_wr));
    chk("addr", 32'(ADDR), 32'(m_a));
    chk("data", 32'(DATA), 32'(m_d));
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("ready", 32'(CMD_READY), 32'(m_rdy));
`ifdef SID_WRSEQ_STATS_EN
    chk("wr_count", 32'(WR_COUNT), 32'(m_cnt));
    chk("starved", 32'(STARVED), 32'(m_starved));
`endif
  endtask

  task automatic idle(input int n, input logic tick);
    for (int i = 0; i < n; i++) step(0, 0, tick, 16'd0, 5'd0, 8'd0);
  endtask

  typedef struct {
    logic rst, vld, tick; logic [15:0] dly; logic [4:0] a; logic [7:0] d;
    logic e_wr; logic [4:0] e_a; logic [7:0] e_d; logic e_busy, e_rdy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int acc, wr_seen, last_wr, gap_bad, ord_bad, nxt, starv;
    // reset, zero-delay write, then DELAY=1 with TICK on the pop edge
    tbl[0]  = '{1,0,0,16'd0,5'h00,8'h00, 0,5'h00,8'h00, 0,1};
    tbl[1]  = '{0,1,0,16'd0,5'h18,8'h0F, 0,5'h00,8'h00, 1,1};
    tbl[2]  = '{0,0,0,16'd0,5'h00,8'h00, 0,5'h00,8'h00, 1,1};
    tbl[3]  = '{0,0,0,16'd0,5'h00,8'h00, 1,5'h18,8'h0F, 1,1};
    tbl[4]  = '{0,0,0,16'd0,5'h00,8'h00, 0,5'h18,8'h0F, 0,1};
    tbl[5]  = '{0,0,1,16'd0,5'h00,8'h00, 0,5'h18,8'h0F, 0,1};
    tbl[6]  = '{0,1,0,16'd1,5'h05,8'hAA, 0,5'h18,8'h0F, 1,1};
    tbl[7]  = '{0,0,1,16'd0,5'h00,8'h00, 0,5'h18,8'h0F, 1,1};
    tbl[8]  = '{0,0,0,16'd0,5'h00,8'h00, 0,5'h18,8'h0F, 1,1};
    tbl[9]  = '{0,0,1,16'd0,5'h00,8'h00, 1,5'h05,8'hAA, 1,1};
    tbl[10] = '{0,0,0,16'd0,5'h00,8'h00, 0,5'h05,8'hAA, 0,1};
    n_edge = 0; m_act = 0; m_rdy = 1; m_wr = 0; m_cnt = 0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].tick, tbl[i].dly, tbl[i].a, tbl[i].d);
      chk("tbl_wr", 32'(WR), 32'(tbl[i].e_wr));
      chk("tbl_addr", 32'(ADDR), 32'(tbl[i].e_a));
      chk("tbl_data", 32'(DATA), 32'(tbl[i].e_d));
      chk("tbl_busy", 32'(BUSY), 32'(tbl[i].e_busy));
      chk("tbl_ready", 32'(CMD_READY), 32'(tbl[i].e_rdy));
    end

    // DELAY=3, TICK every 4 CLK, with a 100-CLK TICK gap after the first TICK
    step(0, 1, 0, 16'd3, 5'h04, 8'h41);
    idle(1, 0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin step(0, 0, i == 3, 16'd0, 5'd0, 8'd0); wr_seen += WR; end
    for (int i = 0; i < 100; i++) begin idle(1, 0); wr_seen += WR; end
    for (int i = 0; i < 4; i++) begin step(0, 0, i == 3, 16'd0, 5'd0, 8'd0); wr_seen += WR; end
    chk("no_wr_before_3rd_tick", 32'(wr_seen), 32'd0);
    for (int i = 0; i < 4; i++) begin step(0, 0, i == 3, 16'd0, 5'd0, 8'd0); wr_seen += WR; end
    chk("wr_on_3rd_tick", 32'(WR), 32'd1);
    chk("wr_3rd_addr_data", {19'd0, ADDR, DATA}, {19'd0, 5'h04, 8'h41});
    idle(3, 0);

    // Fill the FIFO behind a blocked command, then drain zero-delay writes
    step(0, 1, 0, 16'd5, 5'h1F, 8'hEE);
    idle(1, 0);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      if (CMD_READY) acc++;
      step(0, 1, 0, 16'd0, 5'(i), 8'(i * 3));
    end
    chk("accepted_16", 32'(acc), 32'd16);
    chk("ready_low_full", 32'(CMD_READY), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 16'd0, 5'd0, 8'd0);
    chk("blocked_cmd_wr", {19'd0, ADDR, DATA}, {19'd0, 5'h1F, 8'hEE});
    last_wr = 0; gap_bad = 0; ord_bad = 0; nxt = 0;
    for (int i = 1; i <= 40; i++) begin
      idle(1, 0);
      if (WR) begin
        if (ADDR != 5'(nxt) || DATA != 8'(nxt * 3)) ord_bad++;
        if (nxt > 0 && i - last_wr != 2) gap_bad++;
        last_wr = i; nxt++;
      end
    end
    chk("drain_count", 32'(nxt), 32'd16);
    chk("drain_order", 32'(ord_bad), 32'd0);
    chk("drain_spacing", 32'(gap_bad), 32'd0);

    // Reset during WAIT with 5 more queued
    for (int i = 0; i < 6; i++) step(0, 1, 0, (i == 0) ? 16'd4 : 16'd0, 5'(i + 8), 8'(i));
    idle(2, 1);
    step(1, 0, 0, 16'd0, 5'd0, 8'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin idle(1, 1); wr_seen += WR; end
    chk("rst_no_wr", 32'(wr_seen), 32'd0);
    step(0, 1, 0, 16'd0, 5'h18, 8'h0F);
    idle(1, 0);
    idle(1, 0);
    chk("post_rst_wr", {18'd0, WR, ADDR, DATA}, {18'd0, 1'b1, 5'h18, 8'h0F});
    idle(2, 0);

`ifdef SID_WRSEQ_STATS_EN
    // Three queued writes then drain
    step(1, 0, 0, 16'd0, 5'd0, 8'd0);
    starv = 0;
    for (int i = 0; i < 3; i++) begin step(0, 1, 0, 16'd0, 5'(i + 1), 8'(i)); starv += STARVED; end
    for (int i = 0; i < 10; i++) begin idle(1, 0); starv += STARVED; end
    chk("stats_wr_count", 32'(WR_COUNT), 32'd3);
    chk("stats_starved_once", 32'(starv), 32'd1);
`else
    starv = 0;
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 3)),
           5'($urandom), 8'($urandom));
    end
    idle(60, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
